// File: rtl/scope_trigger.sv
// Oscilloscope trigger front end: arms below the hysteresis band, fires on the next rising crossing
// (or after an auto timeout), then box-car decimates a fixed-length frame followed by a holdoff.
module scope_trigger #(
    parameter int DECIM        = 4,
    parameter int FRAME_LEN    = 560,
    parameter int TRIG_LEVEL   = 0,
    parameter int TRIG_HYST    = 256,
    parameter int HOLDOFF      = 1024,
    parameter int AUTO_TIMEOUT = 48000
) (
    input  logic               i_audio_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic signed [15:0] i_data,
    input  logic               i_freeze,
    output logic               o_sample_valid,
    output logic signed [15:0] o_audio_data,
    output logic [1:0]         o_state,
    output logic               o_triggered,
    output logic               o_frame_done
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int ACC_W = 16 + LOG2D;
    localparam int GRP_W = (LOG2D > 0) ? LOG2D : 1;
    localparam int FR_W  = $clog2(FRAME_LEN + 1);
    localparam int HO_W  = $clog2(HOLDOFF + 1);
    localparam int TO_W  = $clog2(AUTO_TIMEOUT + 1);

    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(DECIM - 1);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(FRAME_LEN - 1);
    localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(AUTO_TIMEOUT);
    // Two guard bits keep the thresholds exact even when the band pokes past the 16-bit range.
    localparam logic signed [17:0] LOW_TH  = 18'(TRIG_LEVEL - TRIG_HYST);
    localparam logic signed [17:0] HIGH_TH = 18'(TRIG_LEVEL + TRIG_HYST);

    typedef enum logic [1:0] {
        ST_ARMED     = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_HOLDOFF   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [GRP_W-1:0]        grp_q, grp_d;
    logic [FR_W-1:0]         frame_q, frame_d;
    logic [HO_W-1:0]         ho_q, ho_d;
    logic [TO_W-1:0]         to_q, to_d;
    logic                    valid_q, valid_d;
    logic signed [15:0]      data_q, data_d;
    logic                    trig_q, trig_d;
    logic                    done_q, done_d;

    logic signed [17:0]      data_ext_s;
    logic signed [ACC_W-1:0] sample_acc_s;
    logic signed [ACC_W-1:0] acc_sum_s;
    logic signed [15:0]      acc_avg_s;
    logic [TO_W-1:0]         to_inc_s;
    logic [HO_W-1:0]         ho_inc_s;
    logic                    below_s;
    logic                    above_s;
    logic                    to_hit_s;
    logic                    ho_done_s;
    logic                    grp_end_s;
    logic                    frame_end_s;
    logic                    start_s;
    logic                    real_s;

    // Per-sample arithmetic and threshold conditions feeding the state machine
    always_comb begin
        data_ext_s   = 18'(i_data);
        sample_acc_s = ACC_W'(i_data);
        acc_sum_s    = acc_q + sample_acc_s;
        acc_avg_s    = 16'(acc_sum_s >>> LOG2D);
        below_s      = (data_ext_s < LOW_TH);
        above_s      = (data_ext_s >= HIGH_TH);
        to_inc_s     = to_q + TO_W'(1);
        to_hit_s     = (to_inc_s == TO_LAST);
        ho_inc_s     = (ho_q == HO_LAST) ? ho_q : (ho_q + HO_W'(1));
        ho_done_s    = (ho_inc_s == HO_LAST);
        grp_end_s    = (grp_q == GRP_LAST);
        frame_end_s  = (frame_q == FR_LAST);
    end

    // Next-state logic: everything advances only on accepted samples
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        grp_d   = grp_q;
        frame_d = frame_q;
        ho_d    = ho_q;
        to_d    = to_q;
        valid_d = 1'b0;
        data_d  = data_q;
        trig_d  = trig_q;
        done_d  = 1'b0;
        start_s = 1'b0;
        real_s  = 1'b0;

        if (i_valid) begin
            case (state_q)
                ST_ARMED, ST_WAIT_RISE: begin
                    to_d = to_inc_s;
                    // A genuine rising crossing takes priority over a simultaneous timeout.
                    if ((state_q == ST_WAIT_RISE) && above_s) begin
                        start_s = 1'b1;
                        real_s  = 1'b1;
                    end else if (to_hit_s) begin
                        start_s = 1'b1;
                        real_s  = 1'b0;
                    end else if (below_s) begin
                        state_d = ST_WAIT_RISE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CAPTURE: begin
                    if (grp_end_s) begin
                        acc_d   = '0;
                        grp_d   = '0;
                        valid_d = 1'b1;
                        data_d  = acc_avg_s;
                        if (frame_end_s) begin
                            done_d  = 1'b1;
                            frame_d = '0;
                            ho_d    = '0;
                            state_d = ST_HOLDOFF;
                        end else begin
                            frame_d = frame_q + FR_W'(1);
                        end
                    end else begin
                        acc_d = acc_sum_s;
                        grp_d = grp_q + GRP_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    ho_d = ho_inc_s;
                    if (ho_done_s && !i_freeze) begin
                        state_d = ST_ARMED;
                        ho_d    = '0;
                        to_d    = '0;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // The triggering sample is the first member of the first group.
        if (start_s) begin
            state_d = ST_CAPTURE;
            trig_d  = real_s;
            acc_d   = sample_acc_s;
            grp_d   = GRP_W'(1);
            frame_d = '0;
            to_d    = '0;
        end else begin
            trig_d = trig_q;
        end
    end

    // State and output registers
    always_ff @(posedge i_audio_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ARMED;
            acc_q   <= '0;
            grp_q   <= '0;
            frame_q <= '0;
            ho_q    <= '0;
            to_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= 16'sd0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            grp_q   <= grp_d;
            frame_q <= frame_d;
            ho_q    <= ho_d;
            to_q    <= to_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
        end
    end

    assign o_sample_valid = valid_q;
    assign o_audio_data   = data_q;
    assign o_state        = state_q;
    assign o_triggered    = trig_q;
    assign o_frame_done   = done_q;

endmodule

// File: tb/tb_scope_trigger.sv
// Bench for scope_trigger: random/directed sample streams compared with an array-based model
// that locates the trigger point and averages groups with plain floor division.
module tb_scope_trigger;

    localparam int D    = 4;
    localparam int FL   = 560;
    localparam int HO   = 1024;
    localparam int TO   = 3000;
    localparam int LOW  = 0 - 256;
    localparam int HIGH = 0 + 256;
    localparam int GEN_LEN = TO + D * FL + HO + 10;

    logic               clk    = 1'b0;
    logic               rst_n  = 1'b0;
    logic               valid  = 1'b0;
    logic signed [15:0] din    = 16'sd0;
    logic               freeze = 1'b0;
    logic               sv;
    logic signed [15:0] dout;
    logic [1:0]         st;
    logic               trig;
    logic               done;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_trig = 0;
    int exp_last = 0;
    int gen[$];
    int strobe_log[$];

    always #5 clk = ~clk;

    scope_trigger #(
        .DECIM(D), .FRAME_LEN(FL), .TRIG_LEVEL(0), .TRIG_HYST(256),
        .HOLDOFF(HO), .AUTO_TIMEOUT(TO)
    ) dut (
        .i_audio_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(din), .i_freeze(freeze),
        .o_sample_valid(sv), .o_audio_data(dout), .o_state(st), .o_triggered(trig),
        .o_frame_done(done)
    );

    function automatic int floor_avg(input int s);
        if (s >= 0) return s / D;
        else return -((-s + D - 1) / D);
    endfunction

    function automatic int rand_sample();
        return int'($urandom_range(32'd65535, 32'd0)) - 32768;
    endfunction

    // One accepted sample; outputs are observed 1 time unit after the capturing edge.
    task automatic push(input int x);
        valid = 1'b1;
        din   = 16'(x);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic idle(input string name, input int max_gap);
        int g;
        g = int'($urandom_range(32'(max_gap), 32'd0));
        repeat (g) begin
            @(posedge clk); #1;
            n_cmp++;
            if (sv !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle_pulse: sample_valid=%b frame_done=%b required 0/0", name, sv, done);
            end
        end
    endtask

    // Plays gen[] from an ARMED start and checks every output after every sample.
    task automatic play_frame(input string name, input int max_gap, input bit with_holdoff,
                              input int stop_strobe);
        int j0, t_real, t, e, n, sum, exp_st;
        bit exp_sv, is_real;
        j0 = -1;
        t_real = -1;
        foreach (gen[i]) if (j0 < 0 && gen[i] < LOW) j0 = i;
        if (j0 >= 0) begin
            for (int i = j0 + 1; i < gen.size() && t_real < 0; i++)
                if (gen[i] >= HIGH) t_real = i;
        end
        is_real = (t_real >= 0) && (t_real <= TO - 1);
        t = is_real ? t_real : TO - 1;
        e = t + D * FL - 1;
        n = with_holdoff ? e + HO + 1 : e + 1;
        strobe_log.delete();
        if (gen.size() < n) begin
            $display("FAIL %s stimulus_length: have %0d need %0d", name, gen.size(), n);
            $fatal(1, "stimulus too short");
        end
        for (int i = 0; i < n; i++) begin
            push(gen[i]);
            exp_sv = (i >= t) && (i <= e) && (((i - t) % D) == D - 1);
            if (i == t) exp_trig = is_real ? 1 : 0;
            if (exp_sv) begin
                sum = 0;
                for (int m = 0; m < D; m++) sum += gen[i - m];
                exp_last = floor_avg(sum);
            end
            if (i < t) exp_st = (j0 >= 0 && i >= j0) ? 1 : 0;
            else if (i < e) exp_st = 2;
            else if (i < e + HO) exp_st = 3;
            else exp_st = 0;

            n_cmp++;
            if (sv !== exp_sv) begin
                n_fail++;
                $display("FAIL %s sample_valid@%0d: got %b want %b", name, i, sv, exp_sv);
            end
            n_cmp++;
            if (dout !== 16'(exp_last)) begin
                n_fail++;
                $display("FAIL %s audio_data@%0d: got %0d want %0d", name, i, dout, exp_last);
            end
            n_cmp++;
            if (done !== (exp_sv && i == e)) begin
                n_fail++;
                $display("FAIL %s frame_done@%0d: got %b want %b", name, i, done, (exp_sv && i == e));
            end
            n_cmp++;
            if (st !== 2'(exp_st)) begin
                n_fail++;
                $display("FAIL %s state@%0d: got %0d want %0d", name, i, st, exp_st);
            end
            n_cmp++;
            if (trig !== exp_trig[0]) begin
                n_fail++;
                $display("FAIL %s triggered@%0d: got %b want %0d", name, i, trig, exp_trig);
            end
            if (sv === 1'b1) strobe_log.push_back(int'(dout));
            if (stop_strobe > 0 && strobe_log.size() == stop_strobe) break;
            idle(name, max_gap);
        end
    endtask

    task automatic gen_sine(input int pre_len, input int pre_val);
        int ph;
        ph = int'($urandom_range(32'd99, 32'd0));
        gen.delete();
        for (int i = 0; i < pre_len; i++) gen.push_back(pre_val);
        for (int i = 0; i < GEN_LEN; i++)
            gen.push_back(int'(10000.0 * $sin(6.283185307179586 * real'(i + ph) / 100.0)));
    endtask

    task automatic gen_random();
        gen.delete();
        for (int i = 0; i < GEN_LEN; i++) gen.push_back(rand_sample());
    endtask

    task automatic check_zero_outputs(input string name);
        n_cmp++;
        if (sv !== 1'b0 || dout !== 16'sd0 || st !== 2'd0 || trig !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s reset_outputs: sv=%b data=%0d state=%0d trig=%b done=%b want all 0",
                     name, sv, dout, st, trig, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_trig = 0;
        exp_last = 0;
    endtask

    task automatic test_sine_trigger();
        gen_sine(0, 0);
        play_frame("sine", 1, 1'b1, 0);
        n_cmp++;
        if (strobe_log.size() != FL) begin
            n_fail++;
            $display("FAIL sine strobe_count: got %0d want %0d", strobe_log.size(), FL);
        end
    endtask

    task automatic test_auto_timeout();
        gen.delete();
        for (int i = 0; i < GEN_LEN; i++) gen.push_back(5000);
        play_frame("timeout", 1, 1'b1, 0);
        n_cmp++;
        if (strobe_log.size() != FL || strobe_log[0] != 5000 || strobe_log[FL-1] != 5000) begin
            n_fail++;
            $display("FAIL timeout strobes: count=%0d want %0d, values must be 5000", strobe_log.size(), FL);
        end
    endtask

    task automatic test_rounding();
        int pre[13] = '{-1000, 300, 300, 300, 300, 1, 2, 3, -7, 3, 3, 3, 4};
        gen_random();
        for (int i = 0; i < 13; i++) gen[i] = pre[i];
        play_frame("rounding", 2, 1'b1, 0);
        n_cmp++;
        if (strobe_log.size() < 3 || strobe_log[0] != 300 || strobe_log[1] != -1 || strobe_log[2] != 3) begin
            n_fail++;
            $display("FAIL rounding first_groups: got count=%0d want 300,-1,3", strobe_log.size());
        end
    endtask

    task automatic test_fullscale_square();
        int ph;
        int odd;
        ph = int'($urandom_range(32'd7, 32'd0));
        gen.delete();
        for (int i = 0; i < GEN_LEN; i++) gen.push_back((((i + ph) / 4) % 2 == 0) ? 32767 : -32768);
        play_frame("square", 0, 1'b1, 0);
        odd = 0;
        foreach (strobe_log[i]) if (strobe_log[i] != 32767 && strobe_log[i] != -32768) odd++;
        n_cmp++;
        if (odd != 0 || strobe_log.size() != FL) begin
            n_fail++;
            $display("FAIL square fullscale: %0d non-rail outputs of %0d, want 0 of %0d", odd, strobe_log.size(), FL);
        end
    endtask

    task automatic test_back_to_back();
        gen_random();
        play_frame("b2b_first", 2, 1'b1, 0);
        gen_random();
        play_frame("b2b_second", 0, 1'b1, 0);
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        gen_sine(0, 0);
        play_frame("freeze", 1, 1'b0, 0);
        for (int i = 0; i < HO + 100; i++) begin
            push(rand_sample());
            n_cmp++;
            if (st !== 2'd3 || sv !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze hold@%0d: state=%0d sv=%b want 3/0", i, st, sv);
            end
        end
        freeze = 1'b0;
        push(rand_sample());
        n_cmp++;
        if (st !== 2'd0) begin
            n_fail++;
            $display("FAIL freeze release: state=%0d want 0", st);
        end
    endtask

    task automatic test_reset_mid_capture();
        gen_sine(0, 0);
        play_frame("mid_reset_pre", 1, 1'b0, 200);
        n_cmp++;
        if (strobe_log.size() != 200) begin
            n_fail++;
            $display("FAIL mid_reset strobes_before_reset: got %0d want 200", strobe_log.size());
        end
        rst_n = 1'b0;
        #2;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_trig = 0;
        exp_last = 0;
        gen_sine(300, 8000);
        play_frame("mid_reset_post", 1, 1'b1, 0);
        n_cmp++;
        if (strobe_log.size() != FL) begin
            n_fail++;
            $display("FAIL mid_reset post_frame_strobes: got %0d want %0d", strobe_log.size(), FL);
        end
    endtask

    initial begin
        test_reset();
        test_sine_trigger();
        test_auto_timeout();
        test_rounding();
        test_fullscale_square();
        test_back_to_back();
        test_freeze();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/scope_trigger.md
SCOPE_TRIGGER -- requirements
Module: scope_trigger

Interface
REQ-001 SHALL have parameter DECIM, default 4: input samples per output sample; power of two, 2..64.
REQ-002 SHALL have parameter FRAME_LEN, default 560: output samples per captured frame.
REQ-003 SHALL have parameter TRIG_LEVEL, default 0: signed 16-bit trigger threshold.
REQ-004 SHALL have parameter TRIG_HYST, default 256: hysteresis band, unsigned, applied either side of TRIG_LEVEL.
REQ-005 SHALL have parameter HOLDOFF, default 1024: input samples ignored after each frame.
REQ-006 SHALL have parameter AUTO_TIMEOUT, default 48000: input samples without a trigger before a forced capture.
REQ-007 SHALL have i_audio_clk  in  1  audio bit clock; the only clock.
REQ-008 SHALL have i_rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have i_valid  in  1  one-cycle strobe marking a new input sample.
REQ-010 SHALL have i_data  in  16  signed input sample; qualified by i_valid.
REQ-011 SHALL have i_freeze  in  1  level; holds the current frame on screen.
REQ-012 SHALL have o_sample_valid  out  1  one-cycle strobe marking a new decimated sample for the display stage.
REQ-013 SHALL have o_audio_data  out  16  signed decimated sample; held stable between strobes.
REQ-014 SHALL have o_state  out  2  FSM state: 0 ARMED, 1 WAIT_RISE, 2 CAPTURE, 3 HOLDOFF.
REQ-015 SHALL have o_triggered  out  1  1 = current/last frame started on a real trigger; 0 = auto timeout.
REQ-016 SHALL have o_frame_done  out  1  one-cycle pulse on the last sample of a frame.

Function
REQ-017 SHALL act only on cycles with i_valid=1; all counters advance per accepted sample, never per clock.
REQ-018 ARMED: SHALL move to WAIT_RISE when i_data < TRIG_LEVEL-TRIG_HYST (signed 17-bit compare, no wrap).
REQ-019 WAIT_RISE: SHALL move to CAPTURE when i_data >= TRIG_LEVEL+TRIG_HYST; SHALL set o_triggered=1; this sample SHALL be the first one accumulated.
REQ-020 Auto timeout: SHALL count the samples seen in ARMED+WAIT_RISE; when the count reaches AUTO_TIMEOUT, SHALL enter CAPTURE with o_triggered=0, and that sample SHALL be the first one accumulated.
REQ-021 Real trigger and timeout in the same sample: the real trigger wins (o_triggered=1).
REQ-022 CAPTURE: SHALL sum DECIM consecutive samples into a signed accumulator of 16+log2(DECIM) bits.
REQ-023 CAPTURE output: on the DECIM-th sample, the output SHALL be sum >>> log2(DECIM), arithmetic shift with truncation toward -inf.
REQ-024 The output SHALL drive o_audio_data and pulse o_sample_valid for exactly one cycle, registered: 1 cycle after the i_valid that completed the group.
REQ-025 SHALL clear the accumulator when each group completes; no sample SHALL be lost or double-counted across groups.
REQ-026 After FRAME_LEN outputs, SHALL pulse o_frame_done in the same cycle as the final o_sample_valid and enter HOLDOFF.
REQ-027 HOLDOFF: SHALL count HOLDOFF samples, then enter ARMED and clear the timeout counter.
REQ-028 HOLDOFF with i_freeze=1: SHALL stay in HOLDOFF, and the holdoff count SHALL saturate.
REQ-029 i_freeze in other states SHALL have no effect; a capture in progress always completes.
REQ-030 o_audio_data SHALL hold its last value outside strobes.
REQ-031 o_sample_valid SHALL be low for at least DECIM-1 samples between strobes; the downstream 2-flop edge detector relies on this.
REQ-032 o_triggered SHALL update only on entry to CAPTURE.
REQ-033 i_valid on consecutive cycles SHALL be supported with no lost samples.

Reset
REQ-034 Asserting i_rst_n low SHALL immediately force: o_state=ARMED, o_sample_valid=0, o_audio_data=0, o_triggered=0, o_frame_done=0, all counters and accumulator=0.
REQ-035 Reset mid-CAPTURE SHALL abandon the partial frame; no further strobes until a new trigger.
REQ-036 After release, the first accepted sample SHALL be evaluated by the ARMED rule.

Verification
REQ-037 Sine, amplitude 10000, period 100 samples, defaults -> trigger at the first sample >=256 after a sample <-256; exactly 560 strobes; o_frame_done on the 560th; o_triggered=1; o_state 0→1→2→3→0.
REQ-038 Constant input +5000 for 48000 samples -> CAPTURE entered on the 48000th sample with o_triggered=0; every o_audio_data=5000.
REQ-039 DECIM=4, inputs 1,2,3,-7 after trigger -> o_audio_data=-1 (sum -1 >>> 2); inputs 3,3,3,4 -> 3.
REQ-040 i_freeze=1 held through frame end -> o_state stays 3 indefinitely; release -> after HOLDOFF total samples (counted from frame end), o_state=0.
REQ-041 i_valid every cycle, full-scale ±32767/-32768 square wave -> no accumulator overflow; outputs exactly 32767 and -32768.
REQ-042 Reset asserted after strobe 200 of a frame -> outputs zero immediately; after release, no strobe until the next valid trigger, then a full 560-sample frame.
